bp_inflight_queue: RTL and testbench

- In-order tracking queue for branch predictions, directly downstream of the fetch-stage predictor.
- Stores each predicted instruction's pc, predicted target and predicted direction from fetch until commit.
- At commit it compares the prediction with the real outcome, emits a one-cycle redirect on mispredict, and flushes all younger entries.
- Feeds the commit-side training fields (pc, taken) back to the predictor's counter table.

---
 rtl/bp_inflight_queue_pkg.sv | 34 +++
 rtl/bp_entry_ring.sv | 54 +++++
 rtl/bp_inflight_queue.sv | 102 ++++++++++
 tb/tb_bp_inflight_queue.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_inflight_queue_pkg.sv
// Shared types for the branch-prediction in-flight queue.
// The optional BP_STATS_EN build uses sat_inc for its saturating counters.
package bp_inflight_queue_pkg;

  typedef logic [63:0] addr_t;

  // Next-pc source chosen by fetch; PCJUMP means the predictor said taken.
  typedef enum logic {
    PCPLUS4 = 1'b0,
    PCJUMP  = 1'b1
  } pcsrc_t;

  typedef struct packed {
    addr_t pc;
    addr_t target;
    logic  taken;
  } bp_entry_t;

  typedef struct packed {
    logic  valid;
    addr_t pc;
  } redirect_t;

  // Sequential fall-through pc; wraps naturally at 2^64.
  function automatic addr_t seq_pc(input addr_t pc);
    return pc + 64'd4;
  endfunction

  // 32-bit counter increment that sticks at all-ones.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/bp_entry_ring.sv
// Circular buffer of in-flight predictions: storage, pointers, occupancy.
// clear empties the ring in one cycle and wins over a same-cycle push/pop.
module bp_entry_ring
  import bp_inflight_queue_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  bp_entry_t        push_entry,
  input  logic             pop,
  output bp_entry_t        head,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  bp_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign head  = mem[rd_ptr];
  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_entry;
  end

  // Pointer and occupancy update; a discard aligns rd_ptr to wr_ptr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bp_inflight_queue.sv
// In-order branch prediction tracking queue between fetch and commit.
// Checks each committed prediction, redirects fetch on mispredict and
// drives predictor training. Optional counters: define BP_STATS_EN.
module bp_inflight_queue
  import bp_inflight_queue_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  input  logic           push_valid,
  output logic           push_ready,
  input  addr_t          push_pc,
  input  addr_t          push_target,
  input  logic           push_taken,
  input  logic           resolve_valid,
  input  logic           resolve_is_branch,
  input  logic           resolve_taken,
  input  addr_t          resolve_target,
  output logic           redirect_valid,
  output addr_t          redirect_pc,
  output logic           train_valid,
  output addr_t          train_pc,
  output logic           train_taken,
`ifdef BP_STATS_EN
  output logic [31:0]    stat_resolved,
  output logic [31:0]    stat_mispredict,
`endif
  output logic [PTR_W:0] count
);

  bp_entry_t head;
  bp_entry_t push_entry;
  redirect_t redirect_q;
  pcsrc_t    push_src;
  logic      full, empty;
  logic      push_fire, resolve_fire, mispredict;
  addr_t     correct_pc;

  assign push_src   = push_taken ? PCJUMP : PCPLUS4;
  assign push_entry = '{pc: push_pc, target: push_target, taken: (push_src == PCJUMP)};

  // While a redirect is out, fetch is still on the wrong path: refuse it.
  assign push_ready   = !full && !redirect_q.valid && !flush;
  assign push_fire    = push_valid && push_ready;
  assign resolve_fire = resolve_valid && !empty;

  assign mispredict = resolve_fire &&
                      ((head.taken != resolve_taken) ||
                       (resolve_taken && (head.target != resolve_target)));
  assign correct_pc = resolve_taken ? resolve_target : seq_pc(head.pc);

  // Mispredict or flush discards everything, including a same-cycle push.
  bp_entry_ring #(.DEPTH(DEPTH)) u_ring (
    .clk        (clk),
    .reset      (reset),
    .clear      (flush || mispredict),
    .push       (push_fire && !mispredict),
    .push_entry (push_entry),
    .pop        (resolve_fire && !mispredict),
    .head       (head),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  // One-cycle redirect pulse; an external flush suppresses it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect_q <= '0;
    end else begin
      redirect_q.valid <= mispredict && !flush;
      if (mispredict && !flush) redirect_q.pc <= correct_pc;
    end
  end

  assign redirect_valid = redirect_q.valid;
  assign redirect_pc    = redirect_q.pc;

  // Training is combinational in the resolve cycle; only branches train.
  always_comb begin
    train_valid = resolve_fire && resolve_is_branch;
    train_pc    = head.pc;
    train_taken = resolve_taken;
  end

`ifdef BP_STATS_EN
  // Saturating statistics; flush does not touch them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_resolved   <= '0;
      stat_mispredict <= '0;
    end else begin
      if (resolve_fire && resolve_is_branch) stat_resolved <= sat_inc(stat_resolved);
      if (mispredict) stat_mispredict <= sat_inc(stat_mispredict);
    end
  end
`endif

endmodule

// File: tb/tb_bp_inflight_queue.sv
// Directed self-checking bench for bp_inflight_queue (DEPTH = 8).
module tb_bp_inflight_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        push_valid;
  logic        push_ready;
  logic [63:0] push_pc;
  logic [63:0] push_target;
  logic        push_taken;
  logic        resolve_valid;
  logic        resolve_is_branch;
  logic        resolve_taken;
  logic [63:0] resolve_target;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        train_valid;
  logic [63:0] train_pc;
  logic        train_taken;
  logic [3:0]  count;
`ifdef BP_STATS_EN
  logic [31:0] stat_resolved;
  logic [31:0] stat_mispredict;
  logic [31:0] r0, m0;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bp_inflight_queue #(.DEPTH(8)) dut (
    .clk               (clk),
    .reset             (reset),
    .flush             (flush),
    .push_valid        (push_valid),
    .push_ready        (push_ready),
    .push_pc           (push_pc),
    .push_target       (push_target),
    .push_taken        (push_taken),
    .resolve_valid     (resolve_valid),
    .resolve_is_branch (resolve_is_branch),
    .resolve_taken     (resolve_taken),
    .resolve_target    (resolve_target),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .train_valid       (train_valid),
    .train_pc          (train_pc),
    .train_taken       (train_taken),
`ifdef BP_STATS_EN
    .stat_resolved     (stat_resolved),
    .stat_mispredict   (stat_mispredict),
`endif
    .count             (count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_inputs();
    flush = 0; push_valid = 0; push_pc = '0; push_target = '0; push_taken = 0;
    resolve_valid = 0; resolve_is_branch = 0; resolve_taken = 0; resolve_target = '0;
  endtask

  // Clock the current inputs in, then idle them and let outputs settle.
  task automatic end_cycle();
    @(posedge clk); #1;
    clr_inputs();
    #1;
  endtask

  task automatic set_push(input logic [63:0] pc, input logic [63:0] tgt, input logic tk);
    push_valid = 1; push_pc = pc; push_target = tgt; push_taken = tk;
  endtask

  task automatic set_resolve(input logic br, input logic tk, input logic [63:0] tgt);
    resolve_valid = 1; resolve_is_branch = br; resolve_taken = tk; resolve_target = tgt;
  endtask

  task automatic push_one(input logic [63:0] pc, input logic [63:0] tgt, input logic tk);
    set_push(pc, tgt, tk);
    #1;
    chk("push_ready_on_push", push_ready, 1);
    end_cycle();
  endtask

  initial begin
    clr_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_push_ready", push_ready, 1);
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_train_valid", train_valid, 0);
`ifdef BP_STATS_EN
    chk("rst_stat_resolved", stat_resolved, 0);
    chk("rst_stat_mispredict", stat_mispredict, 0);
`endif
    reset = 0;
    end_cycle();

    // Correct taken prediction: trains, pops, no redirect.
    push_one(64'h8000_0000, 64'h8000_0010, 1);
    chk("t1_count1", count, 1);
    set_resolve(1, 1, 64'h8000_0010);
    #1;
    chk("t1_train_valid", train_valid, 1);
    chk("t1_train_pc", train_pc, 64'h8000_0000);
    chk("t1_train_taken", train_taken, 1);
    end_cycle();
    chk("t1_count0", count, 0);
    chk("t1_no_redirect", redirect_valid, 0);

    // Predicted not-taken, actually taken.
    push_one(64'h100, 64'h0, 0);
    set_resolve(1, 1, 64'h200);
    end_cycle();
    chk("t2_redirect_valid", redirect_valid, 1);
    chk("t2_redirect_pc", redirect_pc, 64'h200);
    chk("t2_count", count, 0);
    chk("t2_push_blocked", push_ready, 0);
    end_cycle();
    chk("t2_redirect_pulse", redirect_valid, 0);
    chk("t2_push_ready_back", push_ready, 1);

    // Predicted taken, actually not taken: fall through.
    push_one(64'h100, 64'h180, 1);
    set_resolve(1, 0, 64'h0);
    end_cycle();
    chk("t3_redirect_valid", redirect_valid, 1);
    chk("t3_redirect_pc", redirect_pc, 64'h104);
    end_cycle();

    // Direction right, target wrong (jump, no training).
    push_one(64'h100, 64'h180, 1);
    set_resolve(0, 1, 64'h190);
    #1;
    chk("t3b_jump_no_train", train_valid, 0);
    end_cycle();
    chk("t3b_redirect_valid", redirect_valid, 1);
    chk("t3b_redirect_pc", redirect_pc, 64'h190);
    end_cycle();

    // Fall-through pc wraps at 2^64.
    push_one(64'hFFFF_FFFF_FFFF_FFFC, 64'h40, 1);
    set_resolve(1, 0, 64'h0);
    end_cycle();
    chk("t3c_redirect_valid", redirect_valid, 1);
    chk("t3c_redirect_wrap", redirect_pc, 64'h0);
    end_cycle();

    // Fill, refused push while full, push+pop steady, in-order drain across wrap.
    for (int i = 0; i < 8; i++) push_one(64'h1000 + 64'(4 * i), 64'h0, 0);
    chk("t4_count_full", count, 8);
    chk("t4_push_ready_full", push_ready, 0);
    set_push(64'h2000, 64'h0, 0);
    set_resolve(1, 0, 64'h0);
    #1;
    chk("t4_full_refuses", push_ready, 0);
    chk("t4_train_pc0", train_pc, 64'h1000);
    end_cycle();
    chk("t4_count7", count, 7);
    set_push(64'h2004, 64'h0, 0);
    set_resolve(1, 0, 64'h0);
    #1;
    chk("t4_push_ready7", push_ready, 1);
    chk("t4_train_pc1", train_pc, 64'h1004);
    end_cycle();
    chk("t4_count_steady", count, 7);
    for (int i = 0; i < 7; i++) begin
      set_resolve(1, 0, 64'h0);
      #1;
      chk("t4_drain_order", train_pc, (i < 6) ? 64'h1008 + 64'(4 * i) : 64'h2004);
      end_cycle();
    end
    chk("t4_count_drained", count, 0);
    chk("t4_no_redirect", redirect_valid, 0);

    // Mispredict drops a same-cycle push.
    push_one(64'h300, 64'h0, 0);
    set_push(64'h500, 64'h0, 0);
    set_resolve(1, 1, 64'h400);
    end_cycle();
    chk("t5_count_after_mp", count, 0);
    chk("t5_redirect_pc", redirect_pc, 64'h400);
    end_cycle();
    chk("t5_still_empty", count, 0);

    // Flush beats mispredict; training still emitted.
    push_one(64'h600, 64'h0, 0);
    flush = 1;
    set_resolve(1, 1, 64'h700);
    #1;
    chk("t5_flush_push_ready", push_ready, 0);
    chk("t5_flush_train", train_valid, 1);
    chk("t5_flush_train_pc", train_pc, 64'h600);
    end_cycle();
    chk("t5_flush_no_redirect", redirect_valid, 0);
    chk("t5_flush_empty", count, 0);

    // Resolve on empty queue is ignored.
    set_resolve(1, 1, 64'h800);
    #1;
    chk("t6_empty_no_train", train_valid, 0);
    end_cycle();
    chk("t6_empty_no_redirect", redirect_valid, 0);
    chk("t6_empty_count", count, 0);

    // Async reset kills a pending redirect immediately.
    push_one(64'h900, 64'h0, 0);
    set_resolve(1, 1, 64'h980);
    end_cycle();
    chk("t7_redirect_pending", redirect_valid, 1);
    reset = 1;
    #1;
    chk("t7_reset_redirect", redirect_valid, 0);
    chk("t7_reset_redirect_pc", redirect_pc, 0);
    chk("t7_reset_push_ready", push_ready, 1);
    reset = 0;
    end_cycle();

`ifdef BP_STATS_EN
    r0 = stat_resolved;
    m0 = stat_mispredict;
    push_one(64'hA00, 64'h0, 0);
    set_resolve(1, 0, 64'h0);
    end_cycle();
    push_one(64'hA10, 64'hA80, 1);
    set_resolve(1, 1, 64'hA80);
    end_cycle();
    push_one(64'hA20, 64'h0, 0);
    set_resolve(1, 1, 64'hB00);
    end_cycle();
    end_cycle();
    chk("stat_resolved_delta", 64'(stat_resolved - r0), 3);
    chk("stat_mispredict_delta", 64'(stat_mispredict - m0), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
